temperature_monitor: RTL

//   Downstream consumer of the 8-bit temperature word from the temperature calculator
//   (base + sensor^2/8, range 0..62).
//   Box-car averages AVG_DEPTH samples and runs a hysteretic thermal FSM (COOL/WARM/HOT/SHUTDOWN).

---
 rtl/temperature_monitor_pkg.sv | 26 ++
 rtl/temperature_monitor_avg.sv | 72 +++++++
 rtl/temperature_monitor.sv | 120 ++++++++++++
 3 files changed

// File: rtl/temperature_monitor_pkg.sv
// Shared state encodings, default thresholds and state decode helpers for the
// temperature monitor.
package temperature_monitor_pkg;

  localparam logic [1:0] ST_COOL = 2'd0;
  localparam logic [1:0] ST_WARM = 2'd1;
  localparam logic [1:0] ST_HOT  = 2'd2;
  localparam logic [1:0] ST_SHUT = 2'd3;

  localparam int DEF_TEMP_W    = 8;
  localparam int DEF_AVG_LOG2  = 2;
  localparam int DEF_WARM_TH   = 35;
  localparam int DEF_HOT_TH    = 45;
  localparam int DEF_CRIT_TH   = 55;
  localparam int DEF_HYST      = 3;
  localparam int DEF_CRIT_HOLD = 2;

  function automatic logic is_alarm(input logic [1:0] st);
    return (st == ST_HOT) || (st == ST_SHUT);
  endfunction

  function automatic logic is_shut(input logic [1:0] st);
    return st == ST_SHUT;
  endfunction

endpackage

// File: rtl/temperature_monitor_avg.sv
// Box-car averaging filter: sample shift buffer, running sum and fill counter.
// avg_temp / avg_valid / upd all register the cycle after sample_valid.
module temp_avg_filter
  import temperature_monitor_pkg::*;
#(
  parameter int TEMP_W   = DEF_TEMP_W,
  parameter int AVG_LOG2 = DEF_AVG_LOG2
) (
  input  logic              clk,
  input  logic              rst_n,
  input  logic              sample_valid,
  input  logic [TEMP_W-1:0] temperature,
  output logic [TEMP_W-1:0] avg_temp,
  output logic              avg_valid,
  output logic              upd
);

  localparam int DEPTH  = 1 << AVG_LOG2;
  localparam int SUM_W  = TEMP_W + AVG_LOG2;
  localparam int FILL_W = AVG_LOG2 + 1;
  localparam logic [FILL_W-1:0] FILL_FULL = FILL_W'(DEPTH);

  logic [TEMP_W-1:0] buf_q [DEPTH];
  logic [TEMP_W-1:0] buf_d [DEPTH];
  logic [SUM_W-1:0]  sum_q, sum_d;
  logic [FILL_W-1:0] fill_q, fill_d;
  logic [TEMP_W-1:0] avg_q, avg_d;
  logic              avg_valid_q, avg_valid_d;
  logic              upd_q, upd_d;

  always_comb begin
    buf_d       = buf_q;
    sum_d       = sum_q;
    fill_d      = fill_q;
    avg_d       = avg_q;
    avg_valid_d = avg_valid_q;
    upd_d       = 1'b0;
    if (sample_valid) begin
      buf_d[0] = temperature;
      for (int i = 1; i < DEPTH; i++) buf_d[i] = buf_q[i-1];
      // Modular add/subtract: the true sum is never negative, so wrap cancels out.
      sum_d = sum_q + SUM_W'(temperature) - SUM_W'(buf_q[DEPTH-1]);
      avg_d = TEMP_W'(sum_d >> AVG_LOG2);
      if (fill_q != FILL_FULL) fill_d = fill_q + FILL_W'(1);
      avg_valid_d = (fill_d == FILL_FULL);
      upd_d       = avg_valid_d;
    end
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      for (int i = 0; i < DEPTH; i++) buf_q[i] <= '0;
      sum_q       <= '0;
      fill_q      <= '0;
      avg_q       <= '0;
      avg_valid_q <= 1'b0;
      upd_q       <= 1'b0;
    end else begin
      for (int i = 0; i < DEPTH; i++) buf_q[i] <= buf_d[i];
      sum_q       <= sum_d;
      fill_q      <= fill_d;
      avg_q       <= avg_d;
      avg_valid_q <= avg_valid_d;
      upd_q       <= upd_d;
    end
  end

  assign avg_temp  = avg_q;
  assign avg_valid = avg_valid_q;
  assign upd       = upd_q;

endmodule

// File: rtl/temperature_monitor.sv
// Thermal monitor: averaged temperature drives a hysteretic COOL/WARM/HOT/SHUTDOWN
// FSM with a sticky, operator-cleared shutdown. All outputs are registered.
module temperature_monitor
  import temperature_monitor_pkg::*;
#(
  parameter int TEMP_W    = DEF_TEMP_W,
  parameter int AVG_LOG2  = DEF_AVG_LOG2,
  parameter int WARM_TH   = DEF_WARM_TH,
  parameter int HOT_TH    = DEF_HOT_TH,
  parameter int CRIT_TH   = DEF_CRIT_TH,
  parameter int HYST      = DEF_HYST,
  parameter int CRIT_HOLD = DEF_CRIT_HOLD
) (
  input  logic              clk,
  input  logic              rst_n,
  input  logic              sample_valid,
  input  logic [TEMP_W-1:0] temperature,
  input  logic              clear_shutdown,
  output logic [TEMP_W-1:0] avg_temp,
  output logic              avg_valid,
  output logic [1:0]        fan_speed,
  output logic              alarm,
  output logic              shutdown,
  output logic [1:0]        therm_state
);

  localparam int CRIT_W = $clog2(CRIT_HOLD + 1);
  localparam logic [TEMP_W-1:0] WARM_UP = TEMP_W'(WARM_TH);
  localparam logic [TEMP_W-1:0] HOT_UP  = TEMP_W'(HOT_TH);
  localparam logic [TEMP_W-1:0] CRIT_UP = TEMP_W'(CRIT_TH);
  localparam logic [TEMP_W-1:0] WARM_DN = TEMP_W'(WARM_TH - HYST);
  localparam logic [TEMP_W-1:0] HOT_DN  = TEMP_W'(HOT_TH - HYST);
  localparam logic [CRIT_W-1:0] CRIT_MAX = CRIT_W'(CRIT_HOLD);

  logic [TEMP_W-1:0] avg;
  logic              upd;

  temp_avg_filter #(
    .TEMP_W   (TEMP_W),
    .AVG_LOG2 (AVG_LOG2)
  ) u_filter (
    .clk          (clk),
    .rst_n        (rst_n),
    .sample_valid (sample_valid),
    .temperature  (temperature),
    .avg_temp     (avg),
    .avg_valid    (avg_valid),
    .upd          (upd)
  );

  logic [1:0]        state_q, state_d;
  logic [CRIT_W-1:0] crit_q, crit_d;
  logic [1:0]        fan_q, fan_d;
  logic              alarm_q, alarm_d;
  logic              shut_q, shut_d;

  always_comb begin
    state_d = state_q;
    crit_d  = crit_q;
    if (upd) begin
      if (avg >= CRIT_UP) begin
        if (crit_q != CRIT_MAX) crit_d = crit_q + CRIT_W'(1);
      end else begin
        crit_d = '0;
      end
    end
    // Shutdown only leaves via operator clear with the registered average below WARM.
    if (state_q == ST_SHUT) begin
      if (clear_shutdown && (avg < WARM_UP)) begin
        state_d = ST_COOL;
        crit_d  = '0;
      end
    end else if (upd) begin
      if (crit_d == CRIT_MAX) begin
        state_d = ST_SHUT;
      end else begin
        case (state_q)
          ST_COOL: begin
            if (avg >= HOT_UP)       state_d = ST_HOT;
            else if (avg >= WARM_UP) state_d = ST_WARM;
          end
          ST_WARM: begin
            if (avg >= HOT_UP)       state_d = ST_HOT;
            else if (avg < WARM_DN)  state_d = ST_COOL;
          end
          ST_HOT: begin
            if (avg < HOT_DN)        state_d = ST_WARM;
          end
          default: state_d = state_q;
        endcase
      end
    end
    fan_d   = state_d;
    alarm_d = is_alarm(state_d);
    shut_d  = is_shut(state_d);
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state_q <= ST_COOL;
      crit_q  <= '0;
      fan_q   <= '0;
      alarm_q <= 1'b0;
      shut_q  <= 1'b0;
    end else begin
      state_q <= state_d;
      crit_q  <= crit_d;
      fan_q   <= fan_d;
      alarm_q <= alarm_d;
      shut_q  <= shut_d;
    end
  end

  assign avg_temp    = avg;
  assign fan_speed   = fan_q;
  assign alarm       = alarm_q;
  assign shutdown    = shut_q;
  assign therm_state = state_q;

endmodule
